// File: rtl/data_sram.sv
// Word-wide data memory for the memory-stage port: byte-lane writes, full-word reads, WAIT_CYCLES stall cycles per access.
// Optional `DSRAM_RANGE_CHK_EN flags addresses above the array and suppresses their effect; otherwise they alias.
module data_sram #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        stall_req_o,
  output logic        addr_err_o
);

  localparam int   DEPTH     = 1 << DEPTH_LOG2;
  localparam logic RstEnable = 1'b1;

  logic [31:0]           mem [DEPTH];
  logic                  wr_en;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic [3:0]            wr_sel;
  logic [31:0]           wr_dat;

  logic [DEPTH_LOG2-1:0] idx_i;
  logic                  oor_i;
  logic                  unused_addr;

  assign idx_i       = addr_i[DEPTH_LOG2+1:2];
  assign unused_addr = ^{addr_i[1:0], addr_i[31:DEPTH_LOG2+2]};

`ifdef DSRAM_RANGE_CHK_EN
  assign oor_i = |addr_i[31:DEPTH_LOG2+2];
`else
  assign oor_i = 1'b0;
`endif

  // Storage is never reset; a reset edge only blocks a commit landing on the same edge.
  always_ff @(posedge clk) begin
    if (wr_en && (rst != RstEnable)) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_sel[b]) begin
          mem[wr_idx][8*b +: 8] <= wr_dat[8*b +: 8];
        end
      end
    end
  end

  generate
    if (WAIT_CYCLES == 0) begin : g_nowait

      always_comb begin
        wr_en       = ce_i & we_i & ~oor_i;
        wr_idx      = idx_i;
        wr_sel      = sel_i;
        wr_dat      = data_i;
        data_o      = '0;
        stall_req_o = 1'b0;
        addr_err_o  = ce_i & oor_i;
        if (ce_i && !we_i && !oor_i) begin
          data_o = mem[idx_i];
        end
      end

    end else begin : g_fsm

      typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
      localparam logic [3:0] NCYC = 4'(WAIT_CYCLES);

      state_t                state_q, state_d;
      logic [3:0]            cnt_q, cnt_d;
      logic                  req_we_q, req_we_d;
      logic                  req_err_q, req_err_d;
      logic [DEPTH_LOG2-1:0] req_idx_q, req_idx_d;
      logic [3:0]            req_sel_q, req_sel_d;
      logic [31:0]           req_dat_q, req_dat_d;
      logic [31:0]           rdata_q, rdata_d;

      always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
          state_q   <= S_IDLE;
          cnt_q     <= '0;
          req_we_q  <= 1'b0;
          req_err_q <= 1'b0;
          req_idx_q <= '0;
          req_sel_q <= '0;
          req_dat_q <= '0;
          rdata_q   <= '0;
        end else begin
          state_q   <= state_d;
          cnt_q     <= cnt_d;
          req_we_q  <= req_we_d;
          req_err_q <= req_err_d;
          req_idx_q <= req_idx_d;
          req_sel_q <= req_sel_d;
          req_dat_q <= req_dat_d;
          rdata_q   <= rdata_d;
        end
      end

      always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_we_d    = req_we_q;
        req_err_d   = req_err_q;
        req_idx_d   = req_idx_q;
        req_sel_d   = req_sel_q;
        req_dat_d   = req_dat_q;
        rdata_d     = rdata_q;
        wr_en       = 1'b0;
        wr_idx      = req_idx_q;
        wr_sel      = req_sel_q;
        wr_dat      = req_dat_q;
        data_o      = '0;
        stall_req_o = 1'b0;
        addr_err_o  = 1'b0;

        case (state_q)
          S_IDLE: begin
            stall_req_o = ce_i;
            if (ce_i) begin
              req_we_d  = we_i;
              req_err_d = oor_i;
              req_idx_d = idx_i;
              req_sel_d = sel_i;
              req_dat_d = data_i;
              cnt_d     = 4'd1;
              if (NCYC == 4'd1) begin
                // Single wait cycle: the access commits straight from the live inputs.
                wr_en   = we_i & ~oor_i;
                wr_idx  = idx_i;
                wr_sel  = sel_i;
                wr_dat  = data_i;
                rdata_d = (we_i || oor_i) ? 32'd0 : mem[idx_i];
                state_d = S_DONE;
              end else begin
                state_d = S_WAIT;
              end
            end
          end

          S_WAIT: begin
            stall_req_o = ce_i;
            if (!ce_i) begin
              // Flush: the pipeline withdrew the request, so nothing commits.
              state_d = S_IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 4'd1;
              if (cnt_d == NCYC) begin
                wr_en   = req_we_q & ~req_err_q;
                rdata_d = (req_we_q || req_err_q) ? 32'd0 : mem[req_idx_q];
                state_d = S_DONE;
              end
            end
          end

          S_DONE: begin
            data_o     = req_we_q ? 32'd0 : rdata_q;
            addr_err_o = req_err_q;
            // The pipeline advances on this edge; a still-high ce_i is the next request.
            state_d    = S_IDLE;
            cnt_d      = '0;
          end

          default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        endcase
      end

    end
  endgenerate

endmodule

// File: tb/tb_data_sram.sv
// Directed bench for data_sram: a wait-state instance checked every cycle against a transaction-level model,
// plus a zero-wait instance checked inline.
module tb_data_sram;

  localparam int N  = 2;
  localparam int DL = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce, we;
  logic [31:0] addr, wdat;
  logic [3:0]  sel;
  logic [31:0] dat2;
  logic        stall2, err2;

  logic        c0_ce, c0_we;
  logic [31:0] c0_addr, c0_wdat;
  logic [3:0]  c0_sel;
  logic [31:0] dat0;
  logic        stall0, err0;

  int errors = 0;
  int checks = 0;

  logic        chk_en = 1'b0;
  logic        exp_stall;
  logic [31:0] exp_data;
  logic        exp_err;

  logic [31:0] mdl [1 << DL];
  logic [31:0] got;

  always #5 clk = ~clk;

  data_sram #(.DEPTH_LOG2(DL), .WAIT_CYCLES(N)) dut (
    .clk(clk), .rst(rst), .ce_i(ce), .we_i(we), .addr_i(addr), .sel_i(sel),
    .data_i(wdat), .data_o(dat2), .stall_req_o(stall2), .addr_err_o(err2)
  );

  data_sram #(.DEPTH_LOG2(DL), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .ce_i(c0_ce), .we_i(c0_we), .addr_i(c0_addr), .sel_i(c0_sel),
    .data_i(c0_wdat), .data_o(dat0), .stall_req_o(stall0), .addr_err_o(err0)
  );

  task automatic check(input string name, input logic [31:0] g, input logic [31:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, g, e);
    end
  endtask

  function automatic logic in_range_err(input logic [31:0] a);
`ifdef DSRAM_RANGE_CHK_EN
    return a[31:DL+2] != '0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [DL-1:0] widx(input logic [31:0] a);
    return a[DL+1:2];
  endfunction

  // Per-cycle comparison of the wait-state instance against the expected outputs.
  always @(negedge clk) begin
    if (chk_en) begin
      check("stall_req_o", {31'd0, stall2}, {31'd0, exp_stall});
      check("data_o", dat2, exp_data);
      check("addr_err_o", {31'd0, err2}, {31'd0, exp_err});
    end
  end

  task automatic expect_out(input logic s, input logic [31:0] d, input logic e);
    exp_stall = s;
    exp_data  = d;
    exp_err   = e;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    ce = 1'b0;
    expect_out(1'b0, 32'd0, 1'b0);
  endtask

  // One full access: N stall cycles, then the DONE cycle; returns data_o seen in DONE.
  task automatic access(input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input logic hold, input logic scramble,
                        output logic [31:0] done_dat);
    logic e;
    e = in_range_err(a);
    @(posedge clk); #1;
    ce = 1'b1; we = w; addr = a; sel = s; wdat = d;
    expect_out(1'b1, 32'd0, 1'b0);
    for (int k = 1; k < N; k++) begin
      @(posedge clk); #1;
      if (scramble) begin
        addr = a ^ 32'h4; wdat = ~d; sel = ~s;
      end
      expect_out(1'b1, 32'd0, 1'b0);
    end
    @(posedge clk); #1;
    if (!hold) ce = 1'b0;
    expect_out(1'b0, (w || e) ? 32'd0 : mdl[widx(a)], e);
    if (w && !e) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) mdl[widx(a)][8*b +: 8] = d[8*b +: 8];
    end
    @(negedge clk); #1;
    done_dat = dat2;
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; we = 1'b0; addr = '0; sel = '0; wdat = '0;
    c0_ce = 1'b0; c0_we = 1'b0; c0_addr = '0; c0_sel = '0; c0_wdat = '0;
    expect_out(1'b0, 32'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    check("reset_data0", dat0, 32'd0);
    check("reset_stall0", {31'd0, stall0}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Basic write/read of word 0x10.
    access(1'b1, 32'h10, 4'hF, 32'h11223344, 1'b0, 1'b0, got);
    idle();
    access(1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 1'b0, got);
    check("read_0x10", got, 32'h11223344);
    idle();

    // Byte-lane writes.
    access(1'b1, 32'h10, 4'b0100, 32'hAAAAAAAA, 1'b0, 1'b0, got);
    idle();
    access(1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 1'b0, got);
    check("lane_sel0100", got, 32'h11AA3344);
    idle();
    access(1'b1, 32'h10, 4'b0011, 32'hBEEFBEEF, 1'b0, 1'b0, got);
    idle();
    access(1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 1'b0, got);
    check("lane_sel0011", got, 32'h11AABEEF);
    check("model_0x10", mdl[widx(32'h10)], 32'h11AABEEF);
    idle();

    // sel=0000 write runs full timing but changes nothing.
    access(1'b1, 32'h10, 4'b0000, 32'h01010101, 1'b0, 1'b0, got);
    access(1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 1'b0, got);
    check("sel0_nowrite", got, 32'h11AABEEF);
    idle();

    // Flush during WAIT.
    access(1'b1, 32'h20, 4'hF, 32'h0, 1'b0, 1'b0, got);
    idle();
    @(posedge clk); #1;
    ce = 1'b1; we = 1'b1; addr = 32'h20; sel = 4'hF; wdat = 32'hDEADBEEF;
    expect_out(1'b1, 32'd0, 1'b0);
    @(posedge clk); #1;
    ce = 1'b0;
    expect_out(1'b0, 32'd0, 1'b0);
    idle();
    access(1'b0, 32'h20, 4'hF, 32'h0, 1'b0, 1'b0, got);
    check("abort_0x20", got, 32'h0);
    idle();

    // Reset during WAIT, landing on the would-be commit edge.
    @(posedge clk); #1;
    ce = 1'b1; we = 1'b1; addr = 32'h20; sel = 4'hF; wdat = 32'hDEADBEEF;
    expect_out(1'b1, 32'd0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    expect_out(1'b1, 32'd0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; ce = 1'b0;
    expect_out(1'b0, 32'd0, 1'b0);
    idle();
    access(1'b0, 32'h20, 4'hF, 32'h0, 1'b0, 1'b0, got);
    check("rst_abort_0x20", got, 32'h0);
    idle();

    // Held request across DONE with inputs scrambled during WAIT.
    access(1'b1, 32'h34, 4'hF, 32'h01020304, 1'b0, 1'b0, got);
    idle();
    access(1'b1, 32'h30, 4'hF, 32'h5555AAAA, 1'b1, 1'b1, got);
    access(1'b0, 32'h30, 4'hF, 32'h0, 1'b0, 1'b0, got);
    check("held_0x30", got, 32'h5555AAAA);
    idle();
    access(1'b0, 32'h34, 4'hF, 32'h0, 1'b0, 1'b0, got);
    check("held_0x34_untouched", got, 32'h01020304);
    idle();

    // Upper-address handling: aliasing or range error.
    access(1'b1, 32'h00001010, 4'hF, 32'hCAFEF00D, 1'b0, 1'b0, got);
    idle();
    access(1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 1'b0, got);
`ifdef DSRAM_RANGE_CHK_EN
    check("range_0x10_kept", got, 32'h11AABEEF);
`else
    check("alias_0x10", got, 32'hCAFEF00D);
`endif
    idle();

    // Zero-wait instance.
    @(posedge clk); #1;
    c0_ce = 1'b1; c0_we = 1'b1; c0_addr = 32'h10; c0_sel = 4'hF; c0_wdat = 32'h11AABEEF;
    @(negedge clk);
    check("n0_wr_data", dat0, 32'd0);
    check("n0_wr_stall", {31'd0, stall0}, 32'd0);
    @(posedge clk); #1;
    c0_we = 1'b0;
    @(negedge clk);
    check("n0_rd", dat0, 32'h11AABEEF);
    check("n0_rd_stall", {31'd0, stall0}, 32'd0);
    check("n0_rd_err", {31'd0, err0}, 32'd0);
    @(posedge clk); #1;
    c0_we = 1'b1; c0_sel = 4'b0001; c0_wdat = 32'h000000FF;
    @(negedge clk);
    check("n0_wr2_data", dat0, 32'd0);
    @(posedge clk); #1;
    c0_we = 1'b0;
    @(negedge clk);
    check("n0_rd_lane", dat0, 32'h11AABEFF);
    @(posedge clk); #1;
    c0_we = 1'b1; c0_addr = 32'h00001010; c0_sel = 4'hF; c0_wdat = 32'h12345678;
    @(negedge clk);
`ifdef DSRAM_RANGE_CHK_EN
    check("n0_range_err", {31'd0, err0}, 32'd1);
`else
    check("n0_range_err", {31'd0, err0}, 32'd0);
`endif
    @(posedge clk); #1;
    c0_we = 1'b0; c0_addr = 32'h10;
    @(negedge clk);
`ifdef DSRAM_RANGE_CHK_EN
    check("n0_range_kept", dat0, 32'h11AABEFF);
`else
    check("n0_alias", dat0, 32'h12345678);
`endif
    @(posedge clk); #1;
    c0_ce = 1'b0;
    @(negedge clk);
    check("n0_idle_data", dat0, 32'd0);
    check("n0_idle_stall", {31'd0, stall0}, 32'd0);

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
